fire2_squeeze_ofm_writer: RTL and testbench

//  Receiving end of the fire2_squeeze output interface. Captures DSP_NO parallel ofm words on each

---
 rtl/fire2_squeeze_ofm_writer_if.sv | 39 +++
 rtl/fire2_squeeze_ofm_writer.sv | 181 ++++++++++++++++++
 tb/tb_fire2_squeeze_ofm_writer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fire2_squeeze_ofm_writer_if.sv
// fire2_squeeze_ofm_writer_if
//   Bundles the signals between the fire2_squeeze layer (producer), the ofm writer,
//   and the next layer's read side.
//   Producer -> writer : sample (1-cycle strobe), ofm[0:DSP_NO-1] (valid with sample),
//                        layer_finish (level)
//   Writer -> producer : ram_feedback (pulse), done, overflow, underflow
//   Reader -> writer   : rd_en, rd_addr (ch*WOUT*WOUT + pix)
//   Writer -> reader   : rd_data, rd_perr (one cycle after rd_en)
//   Modports: master = producer/reader side, slave = the writer.
interface fire2_squeeze_ofm_writer_if #(
  parameter int unsigned WOUT   = 64,
  parameter int unsigned DSP_NO = 16,
  parameter int unsigned WIDTH  = 16
);
  localparam int unsigned DEPTH = DSP_NO * WOUT * WOUT;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic             sample;
  logic [WIDTH-1:0] ofm [0:DSP_NO-1];
  logic             layer_finish;
  logic             ram_feedback;
  logic             done;
  logic             overflow;
  logic             underflow;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_perr;

  modport master (
    output sample, ofm, layer_finish, rd_en, rd_addr,
    input  ram_feedback, done, overflow, underflow, rd_data, rd_perr
  );

  modport slave (
    input  sample, ofm, layer_finish, rd_en, rd_addr,
    output ram_feedback, done, overflow, underflow, rd_data, rd_perr
  );
endinterface

// File: rtl/fire2_squeeze_ofm_writer.sv
// fire2_squeeze_ofm_writer
//   Receiving end of the fire2_squeeze output. Each sample strobe delivers DSP_NO ofm
//   words; they are captured into one of two slots (active/pending) and written one
//   word per cycle into a channel-major RAM at ch*WOUT*WOUT + pix. After the last word
//   of the last pixel, ram_feedback pulses once and done rises until reset.
//   A registered, read-first read port (latency 1) serves the next layer.
// Ports
//   clk  : clock
//   rst  : asynchronous reset, active-low
//   bus  : fire2_squeeze_ofm_writer_if.slave (sample/ofm/layer_finish in, status out,
//          rd_en/rd_addr in, rd_data/rd_perr out)
// Configuration
//   FIRE2_SQUEEZE_OFM_PARITY_EN : store an even-parity bit per word and flag
//   mismatches on read via rd_perr; when undefined rd_perr is tied low.
module fire2_squeeze_ofm_writer #(
  parameter int unsigned WOUT   = 64,
  parameter int unsigned DSP_NO = 16,
  parameter int unsigned WIDTH  = 16
) (
  input logic                        clk,
  input logic                        rst,
  fire2_squeeze_ofm_writer_if.slave  bus
);
  localparam int unsigned PIX   = WOUT * WOUT;
  localparam int unsigned DEPTH = DSP_NO * PIX;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int unsigned PW    = (PIX > 1) ? $clog2(PIX) : 1;
`ifdef FIRE2_SQUEEZE_OFM_PARITY_EN
  localparam int unsigned RW    = WIDTH + 1;
`else
  localparam int unsigned RW    = WIDTH;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_DONE} state_t;

  state_t           state, state_nx;

  logic [WIDTH-1:0] act_buf  [0:DSP_NO-1];
  logic [WIDTH-1:0] pend_buf [0:DSP_NO-1];
  logic             act_full, pend_full;
  logic [CW-1:0]    ch_cnt;
  logic [PW-1:0]    pix_cnt;

  logic             fb_q, done_q, ovf_q, udf_q;

  logic [RW-1:0]    mem [0:DEPTH-1];
  logic [RW-1:0]    rd_q;

  // Decoded controls
  logic             wr_en, last_ch, last_pix;
  logic             act_full_eff, pend_full_eff;
  logic             take, to_act, to_pend, drop, uf_set;
  logic [AW-1:0]    wr_addr;
  logic [RW-1:0]    wr_word;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (act_full) state_nx = ST_DRAIN;
      ST_DRAIN: begin
        if (last_pix)                  state_nx = ST_DONE;
        else if (last_ch && !pend_full) state_nx = ST_IDLE;
      end
      ST_DONE:  state_nx = ST_DONE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs / controls
  // The slot occupancy seen by an incoming sample is the occupancy *after* this
  // cycle's release: finishing a pixel either promotes pending into active or empties
  // active, so a sample in that cycle never overflows and never strands in pending.
  always_comb begin
    wr_en         = (state == ST_DRAIN);
    last_ch       = wr_en && (ch_cnt == CW'(DSP_NO - 1));
    last_pix      = last_ch && (pix_cnt == PW'(PIX - 1));
    act_full_eff  = last_ch ? pend_full : act_full;
    pend_full_eff = last_ch ? 1'b0 : pend_full;
    take          = bus.sample && (state != ST_DONE) && !last_pix;
    to_act        = take && !act_full_eff;
    to_pend       = take && act_full_eff && !pend_full_eff;
    drop          = take && act_full_eff && pend_full_eff;
    uf_set        = bus.layer_finish && !done_q && (state == ST_IDLE) &&
                    !act_full && !pend_full;
    wr_addr       = AW'(ch_cnt) * AW'(PIX) + AW'(pix_cnt);
`ifdef FIRE2_SQUEEZE_OFM_PARITY_EN
    wr_word       = {^act_buf[ch_cnt], act_buf[ch_cnt]};
`else
    wr_word       = act_buf[ch_cnt];
`endif
  end

  // ---------------------------------------------------------------- slot flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_full  <= 1'b0;
      pend_full <= 1'b0;
    end else begin
      if (last_ch) begin
        act_full  <= pend_full;
        pend_full <= 1'b0;
      end
      if (to_act)  act_full  <= 1'b1;
      if (to_pend) pend_full <= 1'b1;
    end
  end

  // Slot data needs no reset; the flags qualify it.
  always_ff @(posedge clk) begin
    if (last_ch && pend_full) act_buf <= pend_buf;
    if (to_act)               act_buf <= bus.ofm;
    if (to_pend)              pend_buf <= bus.ofm;
  end

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_cnt  <= '0;
      pix_cnt <= '0;
    end else if (wr_en) begin
      if (last_ch) begin
        ch_cnt  <= '0;
        pix_cnt <= pix_cnt + PW'(1);
      end else begin
        ch_cnt  <= ch_cnt + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb_q   <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      fb_q <= last_pix;
      if (last_pix) done_q <= 1'b1;
      if (drop)     ovf_q  <= 1'b1;
      if (uf_set)   udf_q  <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  // Non-blocking update of mem makes a same-address read in the write cycle
  // return the previous word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            rd_q <= '0;
    else if (bus.rd_en)  rd_q <= mem[bus.rd_addr];
  end

`ifdef FIRE2_SQUEEZE_OFM_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            perr_q <= 1'b0;
    else if (bus.rd_en)  perr_q <= ^mem[bus.rd_addr];
  end
  assign bus.rd_perr = perr_q;
`else
  assign bus.rd_perr = 1'b0;
`endif

  assign bus.rd_data      = rd_q[WIDTH-1:0];
  assign bus.ram_feedback = fb_q;
  assign bus.done         = done_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fire2_squeeze_ofm_writer.sv
// Testbench for fire2_squeeze_ofm_writer (WOUT=4, DSP_NO=16, WIDTH=16).
// The reference model works on timelines: every accepted sample becomes pixel n,
// its 16 writes land at edges start..start+15, where start is two edges after capture
// or one edge after the previous pixel's last write, whichever is later. A sample is
// accepted when fewer than two captured pixels are still unfinished at its capture edge.
// Reads are predicted from the logged writes (latest write strictly before the read edge).
module tb_fire2_squeeze_ofm_writer;
  localparam int WOUT   = 4;
  localparam int DSP_NO = 16;
  localparam int WIDTH  = 16;
  localparam int PIX    = WOUT * WOUT;
  localparam int DEPTH  = DSP_NO * PIX;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fire2_squeeze_ofm_writer_if #(.WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH)) bus ();

  fire2_squeeze_ofm_writer #(.WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------------------------------------------------------- reference model
  typedef struct { int addr; logic [15:0] data; int t; } wr_t;
  typedef struct { int addr; logic [15:0] data; bit perr; } rd_t;

  wr_t wlog [$];
  rd_t rd_q [$];
  int  fb_q [$];
  int  last_edge [PIX];
  int  acc;
  bit  exp_ovf, exp_udf;

  function automatic void model_sample(input int t, input logic [15:0] d [DSP_NO]);
    int occ, start;
    wr_t w;
    if (acc == PIX) return;
    occ = 0;
    for (int i = 0; i < acc; i++) if (last_edge[i] > t) occ++;
    if (occ >= 2) begin
      exp_ovf = 1'b1;
      return;
    end
    start = t + 2;
    if (acc > 0 && last_edge[acc-1] + 1 > start) start = last_edge[acc-1] + 1;
    last_edge[acc] = start + DSP_NO - 1;
    for (int c = 0; c < DSP_NO; c++) begin
      w.addr = c * PIX + acc;
      w.data = d[c];
      w.t    = start + c;
      wlog.push_back(w);
    end
    if (acc == PIX - 1) fb_q.push_back(last_edge[acc]);
    acc++;
  endfunction

  function automatic void model_lf(input int t);
    if (acc < PIX && (acc == 0 || last_edge[acc-1] < t)) exp_udf = 1'b1;
  endfunction

  // Writes scheduled after edge c never happen once reset lands; RAM itself is not cleared.
  function automatic void model_reset(input int c);
    wr_t keep [$];
    foreach (wlog[i]) if (wlog[i].t <= c) keep.push_back(wlog[i]);
    wlog    = keep;
    acc     = 0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    fb_q.delete();
  endfunction

  function automatic logic [15:0] expect_at(input int addr, input int r);
    logic [15:0] v;
    int best;
    v    = 'x;
    best = -1;
    foreach (wlog[i])
      if (wlog[i].addr == addr && wlog[i].t < r && wlog[i].t > best) begin
        best = wlog[i].t;
        v    = wlog[i].data;
      end
    return v;
  endfunction

  // ---------------------------------------------------------------- drivers (called at negedge)
  task automatic send_sample(input logic [15:0] d [DSP_NO], output int t);
    bus.sample = 1'b1;
    for (int c = 0; c < DSP_NO; c++) bus.ofm[c] = d[c];
    t = cyc + 1;
    model_sample(t, d);
    @(negedge clk);
    bus.sample = 1'b0;
    for (int c = 0; c < DSP_NO; c++) bus.ofm[c] = 16'($urandom);
  endtask

  task automatic send_rand(output int t);
    logic [15:0] d [DSP_NO];
    for (int c = 0; c < DSP_NO; c++) d[c] = 16'($urandom);
    send_sample(d, t);
  endtask

  task automatic do_read(input int addr, input bit perr, input logic [15:0] flip);
    rd_t e;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 8'(addr);
    e.addr = addr;
    e.data = expect_at(addr, cyc + 1) ^ flip;
    e.perr = perr;
    rd_q.push_back(e);
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_lf();
    bus.layer_finish = 1'b1;
    model_lf(cyc + 1);
    @(negedge clk);
    bus.layer_finish = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    model_reset(cyc);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_done"},      bus.done,      (acc == PIX));
    check({tag, "_overflow"},  bus.overflow,  exp_ovf);
    check({tag, "_underflow"}, bus.underflow, exp_udf);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done"},         bus.done,         0);
    check({tag, "_ram_feedback"}, bus.ram_feedback, 0);
    check({tag, "_overflow"},     bus.overflow,     0);
    check({tag, "_underflow"},    bus.underflow,    0);
    check({tag, "_rd_data"},      bus.rd_data,      0);
    check({tag, "_rd_perr"},      bus.rd_perr,      0);
  endtask

  // ---------------------------------------------------------------- monitors
  always @(posedge clk) begin
    rd_t e;
    if (bus.rd_en) begin
      #1;
      if (rd_q.size() == 0) begin
        n_checks++;
        $display("FAIL rd_unexpected: got read data %0h with no read outstanding", bus.rd_data);
      end else begin
        e = rd_q.pop_front();
        check($sformatf("rd_data[%0d]", e.addr), bus.rd_data, e.data);
        check($sformatf("rd_perr[%0d]", e.addr), bus.rd_perr, e.perr);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && bus.ram_feedback) begin
      if (fb_q.size() == 0) begin
        n_checks++;
        $display("FAIL ram_feedback_extra: got pulse at cycle %0d expected none", cyc);
      end else begin
        check("ram_feedback_cycle", cyc, fb_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [15:0] d [DSP_NO];
    int t, w, guard;

    bus.sample = 1'b0;
    bus.layer_finish = 1'b0;
    bus.rd_en = 1'b0;
    bus.rd_addr = '0;
    for (int c = 0; c < DSP_NO; c++) bus.ofm[c] = '0;
    model_reset(0);

    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Full frame with patterned data, samples 577 cycles apart
    for (int p = 0; p < PIX; p++) begin
      for (int c = 0; c < DSP_NO; c++) d[c] = 16'((p << 8) | c);
      send_sample(d, t);
      repeat (576) @(negedge clk);
    end
    check("frame1_feedback_seen", fb_q.size(), 0);
    check_flags("frame1");
    send_rand(t);                   // ignored once done
    repeat (20) @(negedge clk);
    check_flags("frame1_after_done");
    for (int a = 0; a < DEPTH; a++) do_read(a, 1'b0, 16'h0);
    repeat (3) @(negedge clk);

    // Sample landing on the pending->active promotion edge
    apply_reset();
    send_rand(t);
    send_rand(t);
    w = last_edge[0];
    while (cyc < w - 1) @(negedge clk);
    send_rand(t);
    repeat (60) @(negedge clk);
    check_flags("promote");

    // Three back-to-back samples: third dropped; layer_finish while busy is harmless
    send_rand(t);
    send_rand(t);
    send_rand(t);
    repeat (5) @(negedge clk);
    pulse_lf();
    repeat (50) @(negedge clk);
    check_flags("burst");

    // layer_finish with everything drained
    pulse_lf();
    @(negedge clk);
    check_flags("underflow");
    for (int k = 0; k < 3; k++) begin
      send_rand(t);
      repeat (25) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check_flags("post_underflow");
    for (int c = 0; c < DSP_NO; c++)
      for (int p = 0; p < 8; p++) do_read(c * PIX + p, 1'b0, 16'h0);
    repeat (3) @(negedge clk);

    // Read-first on address 17 (ch1 of pixel 1); RAM keeps the earlier frame's word
    apply_reset();
    send_rand(t);
    repeat (25) @(negedge clk);
    send_rand(t);
    w = last_edge[1] - (DSP_NO - 1) + 1;
    while (cyc < w - 1) @(negedge clk);
    do_read(17, 1'b0, 16'h0);
    do_read(17, 1'b0, 16'h0);
    repeat (25) @(negedge clk);

    // Reset in the middle of pixel 3's drain
    send_rand(t);
    repeat (25) @(negedge clk);
    send_rand(t);
    w = last_edge[3] - (DSP_NO - 1);
    while (cyc < w + 4) @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset(cyc);
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Fresh frame with random spacing (some samples may overflow and be re-sent)
    guard = 0;
    while (acc < PIX && guard < 300) begin
      send_rand(t);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      guard++;
    end
    check("frame2_all_accepted", acc, PIX);
    repeat (80) @(negedge clk);
    check("frame2_feedback_seen", fb_q.size(), 0);
    check_flags("frame2");
    for (int a = 0; a < DEPTH; a++) do_read(a, 1'b0, 16'h0);
    repeat (3) @(negedge clk);

`ifdef FIRE2_SQUEEZE_OFM_PARITY_EN
    dut.mem[5][0] = ~dut.mem[5][0];
    do_read(5, 1'b1, 16'h0001);
    repeat (3) @(negedge clk);
`endif

    check("rd_scoreboard_drained", rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
